// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared state encoding, word geometry and address check for the data-memory responder
package dmem_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam int WORD_BYTES = 4;
    localparam int WORD_LSB   = 2;

    // Misaligned byte offset or a word index past the end of storage; indices never wrap.
    function automatic logic addr_err(input logic [WORD_LSB-1:0] byte_off,
                                      input logic [63:0]         word_idx,
                                      input int unsigned         depth_words);
        return (byte_off != '0) || (word_idx >= 64'(depth_words));
    endfunction

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - single-port word storage, synchronous write, combinational read, no reset
module dmem_array #(
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = 10
) (
    input  logic              clock,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

    // Store port: contents survive reset by design.
    always_ff @(posedge clock) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - MEM-stage load/store target with wait states; DMEM_PERF_CNT_EN builds the perf counters
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    output logic [31:0]       perf_reads,
    output logic [31:0]       perf_writes,
    output logic [31:0]       perf_wait_cyc
);

    localparam int IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int WCNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam int BYTE_OFF_W = $clog2(WORD_BYTES);

    logic [1:0]        state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;

    logic              write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              rsp_err_q;

    logic              accept;
    logic              enter_resp;
    logic [ADDR_W-1:0] look_addr;
    logic              look_write;
    logic [63:0]       look_idx;
    logic              look_err;
    logic [IDX_W-1:0]  arr_idx;
    logic              arr_we;
    logic [DATA_W-1:0] arr_rdata;

    assign req_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign accept    = req_ready && req_valid;

    // The response is computed on the edge entering RESP, so with zero wait
    // states the request comes straight from the ports instead of the latch.
    assign look_addr  = req_ready ? req_addr  : addr_q;
    assign look_write = req_ready ? req_write : write_q;
    assign look_idx   = 64'(look_addr[ADDR_W-1:WORD_LSB]);
    assign look_err   = addr_err(look_addr[BYTE_OFF_W-1:0], look_idx, DEPTH_WORDS);
    assign enter_resp = (state_d == ST_RESP);

    // Single port: RESP owns it for the store, every other state for the lookahead read.
    assign arr_idx = (state_q == ST_RESP) ? addr_q[WORD_LSB +: IDX_W] : look_addr[WORD_LSB +: IDX_W];
    assign arr_we  = (state_q == ST_RESP) && write_q && !rsp_err_q && !reset;

    dmem_array #(
        .DATA_W      (DATA_W),
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clock   (clock),
        .we_i    (arr_we),
        .addr_i  (arr_idx),
        .wdata_i (wdata_q),
        .rdata_o (arr_rdata)
    );

    // Next-state and wait-counter decode.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                        wcnt_d  = WCNT_W'(WAIT_CYCLES - 1);
                    end
                end
            end
            ST_WAIT: begin
                if (wcnt_q == '0) begin
                    state_d = ST_RESP;
                end else begin
                    wcnt_d = wcnt_q - WCNT_W'(1);
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state and registered response outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            wcnt_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            rsp_valid_q <= enter_resp;
            rsp_err_q   <= enter_resp && look_err;
            rsp_rdata_q <= (enter_resp && !look_write && !look_err) ? arr_rdata : '0;
        end
    end

    // Request capture on accept; inputs are ignored after that.
    always_ff @(posedge clock) begin
        if (accept) begin
            write_q <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

`ifdef DMEM_PERF_CNT_EN
    logic [31:0] perf_reads_q, perf_writes_q, perf_wait_q;

    // Error-free completions are counted in RESP; every WAIT cycle is counted.
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_reads_q  <= '0;
            perf_writes_q <= '0;
            perf_wait_q   <= '0;
        end else begin
            if ((state_q == ST_RESP) && !rsp_err_q) begin
                if (write_q) begin
                    perf_writes_q <= perf_writes_q + 32'd1;
                end else begin
                    perf_reads_q <= perf_reads_q + 32'd1;
                end
            end
            if (state_q == ST_WAIT) begin
                perf_wait_q <= perf_wait_q + 32'd1;
            end
        end
    end

    assign perf_reads    = perf_reads_q;
    assign perf_writes   = perf_writes_q;
    assign perf_wait_cyc = perf_wait_q;
`else
    assign perf_reads    = '0;
    assign perf_writes   = '0;
    assign perf_wait_cyc = '0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - table, hand-sequence and randomized checks of dmem_responder against a word-array model
module tb_dmem_responder;

    localparam int DEPTH = 64;
    localparam int W_A   = 2;
    localparam int W_B   = 0;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid     [2];
    logic        req_ready     [2];
    logic        req_write     [2];
    logic [31:0] req_addr      [2];
    logic [31:0] req_wdata     [2];
    logic        rsp_valid     [2];
    logic [31:0] rsp_rdata     [2];
    logic        rsp_err       [2];
    logic        busy          [2];
    logic [31:0] perf_reads    [2];
    logic [31:0] perf_writes   [2];
    logic [31:0] perf_wait_cyc [2];

    always #5 clock = ~clock;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        dmem_responder #(
            .ADDR_W      (32),
            .DATA_W      (32),
            .DEPTH_WORDS (DEPTH),
            .WAIT_CYCLES ((g == 0) ? W_A : W_B)
        ) u_dut (
            .clock         (clock),
            .reset         (reset),
            .req_valid     (req_valid[g]),
            .req_ready     (req_ready[g]),
            .req_write     (req_write[g]),
            .req_addr      (req_addr[g]),
            .req_wdata     (req_wdata[g]),
            .rsp_valid     (rsp_valid[g]),
            .rsp_rdata     (rsp_rdata[g]),
            .rsp_err       (rsp_err[g]),
            .busy          (busy[g]),
            .perf_reads    (perf_reads[g]),
            .perf_writes   (perf_writes[g]),
            .perf_wait_cyc (perf_wait_cyc[g])
        );
    end

    int n_vec = 0;
    int n_bad = 0;

    logic [31:0] mem_m   [2][DEPTH];
    bit          known_m [2][DEPTH];
    int unsigned m_rd [2];
    int unsigned m_wr [2];
    int unsigned m_wc [2];

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic        e;
        logic [31:0] r;
    } vec_t;

    vec_t tbl [11];

    function automatic int waits(input int k);
        return (k == 0) ? W_A : W_B;
    endfunction

    function automatic bit model_err(input logic [31:0] a);
        return ((a % 4) != 0) || ((a / 4) >= DEPTH);
    endfunction

    function automatic logic [31:0] perf_exp(input int unsigned v);
`ifdef DMEM_PERF_CNT_EN
        return v;
`else
        return (v == 0) ? 32'd0 : 32'd0;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic model_commit(input int k, input logic w, input logic [31:0] a, input logic [31:0] d);
        if (!model_err(a)) begin
            if (w) begin
                mem_m[k][a / 4]   = d;
                known_m[k][a / 4] = 1'b1;
                m_wr[k]++;
            end else begin
                m_rd[k]++;
            end
        end
        m_wc[k] += waits(k);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clock);
            req_valid[0] = 1'b0;
            req_valid[1] = 1'b0;
        end
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clock);
        reset = 1'b1;
        req_valid[0] = 1'b0;
        req_valid[1] = 1'b0;
        repeat (cycles) @(negedge clock);
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_rd[k] = 0;
            m_wr[k] = 0;
            m_wc[k] = 0;
        end
    endtask

    // One request; lat counts cycles from the cycle after accept to the response (1 = next cycle).
    task automatic txn(input int k, input logic w, input logic [31:0] a, input logic [31:0] d, input bit junk,
                       output logic [31:0] rd, output logic er, output int lat);
        int guard;
        @(negedge clock);
        req_valid[1 - k] = 1'b0;
        guard = 0;
        while (req_ready[k] !== 1'b1 && guard < 20) begin
            @(negedge clock);
            guard++;
        end
        req_valid[k] = 1'b1;
        req_write[k] = w;
        req_addr[k]  = a;
        req_wdata[k] = d;
        @(posedge clock);
        @(negedge clock);
        lat = 1;
        while (1) begin
            if (junk) begin
                req_valid[k] = 1'($urandom_range(0, 1));
                req_write[k] = 1'b1;
                req_addr[k]  = $urandom_range(0, DEPTH - 1) * 4;
                req_wdata[k] = $urandom;
            end else begin
                req_valid[k] = 1'b0;
            end
            if (rsp_valid[k] === 1'b1 || lat >= 20) break;
            @(negedge clock);
            lat++;
        end
        rd = rsp_rdata[k];
        er = rsp_err[k];
    endtask

    task automatic do_op(input int k, input logic w, input logic [31:0] a, input logic [31:0] d, input bit junk);
        logic [31:0] rd;
        logic        er;
        int          lat;
        bit          e;
        bit          known;
        logic [31:0] exp_rd;
        e      = model_err(a);
        known  = 1'b1;
        exp_rd = 32'd0;
        if (!e && !w) begin
            known  = known_m[k][a / 4];
            exp_rd = mem_m[k][a / 4];
        end
        txn(k, w, a, d, junk, rd, er, lat);
        chk($sformatf("op%0d_lat @%08h", k, a), lat, 1 + waits(k));
        chk($sformatf("op%0d_err @%08h", k, a), er, e);
        if (known) chk($sformatf("op%0d_rdata @%08h", k, a), rd, exp_rd);
        model_commit(k, w, a, d);
    endtask

    task automatic chk_perf(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s_reads%0d", tag, k),  perf_reads[k],    perf_exp(m_rd[k]));
            chk($sformatf("%s_writes%0d", tag, k), perf_writes[k],   perf_exp(m_wr[k]));
            chk($sformatf("%s_wait%0d", tag, k),   perf_wait_cyc[k], perf_exp(m_wc[k]));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          seen;

        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            req_valid[k] = 1'b0;
            req_write[k] = 1'b0;
            req_addr[k]  = '0;
            req_wdata[k] = '0;
            m_rd[k] = 0;
            m_wr[k] = 0;
            m_wc[k] = 0;
            for (int i = 0; i < DEPTH; i++) known_m[k][i] = 1'b0;
        end

        // Reset state
        do_reset(3);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_rsp_valid%0d", k), rsp_valid[k], 0);
            chk($sformatf("rst_rsp_rdata%0d", k), rsp_rdata[k], 0);
            chk($sformatf("rst_rsp_err%0d", k),   rsp_err[k],   0);
            chk($sformatf("rst_busy%0d", k),      busy[k],      0);
            chk($sformatf("rst_ready%0d", k),     req_ready[k], 1);
        end
        chk_perf("rst");

        // Store/load, errors and the boundary index on the two-wait-state instance
        tbl[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0};
        tbl[1]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
        tbl[2]  = '{1'b1, 32'h0000_0000, 32'hA5A5_0000, 1'b0, 32'h0};
        tbl[3]  = '{1'b0, 32'h0000_0012, 32'h0,         1'b1, 32'h0};
        tbl[4]  = '{1'b1, DEPTH * 4,     32'h0000_1111, 1'b1, 32'h0};
        tbl[5]  = '{1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'hA5A5_0000};
        tbl[6]  = '{1'b1, (DEPTH-1) * 4, 32'hCAFE_F00D, 1'b0, 32'h0};
        tbl[7]  = '{1'b0, (DEPTH-1) * 4, 32'h0,         1'b0, 32'hCAFE_F00D};
        tbl[8]  = '{1'b0, DEPTH * 4,     32'h0,         1'b1, 32'h0};
        tbl[9]  = '{1'b1, 32'h0000_0003, 32'h7777_7777, 1'b1, 32'h0};
        tbl[10] = '{1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'hA5A5_0000};
        for (int i = 0; i < 11; i++) begin
            txn(0, tbl[i].w, tbl[i].a, tbl[i].d, 1'b0, rd, er, lat);
            chk($sformatf("tbl%0d_lat", i),   lat, 1 + W_A);
            chk($sformatf("tbl%0d_err", i),   er,  tbl[i].e);
            chk($sformatf("tbl%0d_rdata", i), rd,  tbl[i].r);
            model_commit(0, tbl[i].w, tbl[i].a, tbl[i].d);
        end

        // Zero wait states, req_valid held high: accept every other cycle
        @(negedge clock);
        for (int c = 0; c < 6; c++) begin
            if (c > 0) @(negedge clock);
            chk($sformatf("b2b_ready_c%0d", c),     req_ready[1], (c % 2 == 0));
            chk($sformatf("b2b_rsp_valid_c%0d", c), rsp_valid[1], (c % 2 == 1));
            req_valid[1] = 1'b1;
            req_write[1] = 1'b1;
            req_addr[1]  = 32'h40 + 4 * c;
            req_wdata[1] = 32'h100 + c;
        end
        idle(1);
        model_commit(1, 1'b1, 32'h40, 32'h100);
        model_commit(1, 1'b1, 32'h48, 32'h102);
        model_commit(1, 1'b1, 32'h50, 32'h104);
        do_op(1, 1'b0, 32'h40, 32'h0, 1'b0);
        do_op(1, 1'b0, 32'h48, 32'h0, 1'b0);
        do_op(1, 1'b0, 32'h50, 32'h0, 1'b0);
        chk("b2b_load40", mem_m[1][16], 32'h100);

        // Reset while a store is waiting: store dropped, no response
        do_op(0, 1'b1, 32'h20, 32'h5555_AAAA, 1'b0);
        @(negedge clock);
        req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 32'h20; req_wdata[0] = 32'h1234;
        @(posedge clock);
        @(negedge clock);
        req_valid[0] = 1'b0;
        chk("rstwait_busy_before", busy[0], 1);
        reset = 1'b1;
        @(negedge clock);
        chk("rstwait_busy_after",  busy[0],      0);
        chk("rstwait_ready_after", req_ready[0], 1);
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin m_rd[k] = 0; m_wr[k] = 0; m_wc[k] = 0; end
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            if (rsp_valid[0] === 1'b1) seen++;
            @(negedge clock);
        end
        chk("rstwait_no_rsp", seen, 0);
        txn(0, 1'b0, 32'h20, 32'h0, 1'b0, rd, er, lat);
        chk("rstwait_old_data", rd, 32'h5555_AAAA);
        model_commit(0, 1'b0, 32'h20, 32'h0);

        // Reset during the RESP cycle of a store: the store must not commit
        do_op(0, 1'b1, 32'h24, 32'h600D_600D, 1'b0);
        @(negedge clock);
        req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 32'h24; req_wdata[0] = 32'hBAD0_BAD0;
        @(posedge clock);
        repeat (1 + W_A) @(negedge clock);
        req_valid[0] = 1'b0;
        chk("rstresp_in_resp", rsp_valid[0], 1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("rstresp_valid_cleared", rsp_valid[0], 0);
        txn(0, 1'b0, 32'h24, 32'h0, 1'b0, rd, er, lat);
        chk("rstresp_old_data", rd, 32'h600D_600D);

        // Performance counters: 3 loads + 2 stores, one of them out of range
        do_reset(1);
        do_op(0, 1'b0, 32'h10,          32'h0,       1'b0);
        do_op(0, 1'b0, 32'h00,          32'h0,       1'b0);
        do_op(0, 1'b0, (DEPTH - 1) * 4, 32'h0,       1'b0);
        do_op(0, 1'b1, 32'h14,          32'h1357_9BDF, 1'b0);
        do_op(0, 1'b1, DEPTH * 4,       32'h2468_ACE0, 1'b0);
`ifdef DMEM_PERF_CNT_EN
        chk("perf_reads_fixed",  perf_reads[0],    32'd3);
        chk("perf_writes_fixed", perf_writes[0],   32'd1);
        chk("perf_wait_fixed",   perf_wait_cyc[0], 32'd10);
`else
        chk("perf_reads_fixed",  perf_reads[0],    32'd0);
        chk("perf_writes_fixed", perf_writes[0],   32'd0);
        chk("perf_wait_fixed",   perf_wait_cyc[0], 32'd0);
`endif

        // Randomized traffic on both instances, with junk requests while busy
        for (int i = 0; i < 300; i++) begin
            int          k;
            logic [31:0] a;
            logic        w;
            k = i % 2;
            w = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) begin
                a = $urandom;
            end else begin
                a = $urandom_range(0, DEPTH + 3) * 4;
                if ($urandom_range(0, 3) == 0) a = a + $urandom_range(1, 3);
            end
            do_op(k, w, a, $urandom, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(1);
        chk_perf("final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
